// File: rtl/char_plotter.sv
// Glyph plotter: fetches an 8x8 bitmap for a character code and streams it as pixel writes.
// Optional CHAR_PLOTTER_TRANSPARENT_BG_EN: clear glyph bits are skipped instead of painted.
module char_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         char_code,
  input  logic [X_W-1:0]     x_origin,
  input  logic [Y_W-1:0]     y_origin,
  input  logic [COLOR_W-1:0] fg_colour,
  input  logic [COLOR_W-1:0] bg_colour,
  output logic [7:0]         digit,
  input  logic [63:0]        pixelLine,
  input  logic               plot_ready,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         digit_q, digit_d;
  logic [X_W-1:0]     x0_q, x0_d;
  logic [Y_W-1:0]     y0_q, y0_d;
  logic [COLOR_W-1:0] fg_q, fg_d;
  logic [COLOR_W-1:0] bg_q, bg_d;
  logic [63:0]        glyph_q, glyph_d;
  logic [5:0]         k_q, k_d;

  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic         bit_set;
  logic         clipped;
  logic         skip;
  logic         adv;

  // One extra bit on the coordinates keeps edge cells from wrapping back on-screen.
  always_comb begin
    px      = {1'b0, x0_q} + {{(X_W-2){1'b0}}, k_q[2:0]};
    py      = {1'b0, y0_q} + {{(Y_W-2){1'b0}}, k_q[5:3]};
    bit_set = glyph_q[6'd63 - k_q];
    clipped = (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));
`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
    skip    = clipped || !bit_set;
`else
    skip    = clipped;
`endif
    adv     = (state_q == DRAW) && (skip || plot_ready);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      digit_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      glyph_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      glyph_q <= glyph_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    glyph_d = glyph_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          digit_d = char_code;
          x0_d    = x_origin;
          y0_d    = y_origin;
          fg_d    = fg_colour;
          bg_d    = bg_colour;
          state_d = LOAD;
        end
      end
      LOAD: begin
        glyph_d = pixelLine;
        k_d     = '0;
        state_d = DRAW;
      end
      DRAW: begin
        if (adv) begin
          if (k_q == 6'd63) state_d = DONE;
          else              k_d = k_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    plot       = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    digit      = digit_q;
    unique case (state_q)
      DRAW: begin
        vga_x      = px[X_W-1:0];
        vga_y      = py[Y_W-1:0];
        vga_colour = bit_set ? fg_q : bg_q;
        plot       = !skip;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_char_plotter.sv
// Self-checking bench for char_plotter: random glyphs, origins and ready patterns
// compared against a pixel-list reference model.
module tb_char_plotter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  char_code;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;
  logic [2:0]  fg_colour;
  logic [2:0]  bg_colour;
  logic [7:0]  digit;
  logic [63:0] pixelLine;
  logic        plot_ready;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [63:0] rom [256];
  logic        rpat [4096];

  typedef struct {int x; int y; int c;} pix_t;

  assign pixelLine = rom[digit];

  char_plotter dut (
    .clock(clock), .reset(reset), .start(start), .char_code(char_code),
    .x_origin(x_origin), .y_origin(y_origin),
    .fg_colour(fg_colour), .bg_colour(bg_colour),
    .digit(digit), .pixelLine(pixelLine), .plot_ready(plot_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic rdy(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 2) == 1;
      2:       return rpat[t];
      default: return (t == 2) || (t == 65);
    endcase
  endfunction

`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  task automatic run_draw(input logic [7:0] code, input int x0, input int y0,
                          input logic [2:0] fg, input logic [2:0] bg,
                          input int mode, input int restart_at,
                          output int done_cyc, output int nplots);
    logic [63:0] g;
    pix_t exp_q[$];
    pix_t obs_q[$];
    pix_t p;
    int exp_done, t;
    logic pv_plot, pv_rdy;
    logic [7:0] pv_x;
    logic [6:0] pv_y;
    logic [2:0] pv_c;
    g = rom[code];
    exp_done = 2;
    for (int k = 0; k < 64; k++) begin
      int x, y;
      logic b, vis;
      x = x0 + k % 8;
      y = y0 + k / 8;
      b = g[63-k];
      vis = (x < 160) && (y < 120) && (b || !TRANSP);
      if (vis) begin
        p.x = x; p.y = y; p.c = b ? int'(fg) : int'(bg);
        exp_q.push_back(p);
        while (!rdy(mode, exp_done) && exp_done < 4000) exp_done++;
      end
      exp_done++;
    end
    done_cyc = -1;
    pv_plot = 1'b0; pv_rdy = 1'b0; pv_x = '0; pv_y = '0; pv_c = '0;
    @(posedge clock); #1;
    t = 0;
    start = 1'b1; char_code = code;
    x_origin = x0[7:0]; y_origin = y0[6:0];
    fg_colour = fg; bg_colour = bg;
    plot_ready = rdy(mode, 0);
    forever begin
      @(negedge clock);
      checks++;
      if (t == 0 && busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_idle t=%0d got=%b want=0", t, busy);
      end
      if (t >= 1 && (busy !== 1'b1 || digit !== code)) begin
        failures++;
        $display("FAIL busy_digit t=%0d busy=%b digit=%h want busy=1 digit=%h",
                 t, busy, digit, code);
      end
      if (pv_plot && !pv_rdy) begin
        checks++;
        if (plot !== 1'b1 || vga_x !== pv_x || vga_y !== pv_y || vga_colour !== pv_c) begin
          failures++;
          $display("FAIL hold t=%0d got=(%0d,%0d,%0d,%b) want=(%0d,%0d,%0d,1)",
                   t, vga_x, vga_y, vga_colour, plot, pv_x, pv_y, pv_c);
        end
      end
      pv_plot = plot; pv_rdy = plot_ready;
      pv_x = vga_x; pv_y = vga_y; pv_c = vga_colour;
      if (plot === 1'b1 && plot_ready === 1'b1) begin
        p.x = int'(vga_x); p.y = int'(vga_y); p.c = int'(vga_colour);
        obs_q.push_back(p);
      end
      if (done === 1'b1) begin
        done_cyc = t;
        break;
      end
      if (t >= 3000) begin
        failures++;
        $display("FAIL timeout t=%0d got=no_done want=done", t);
        break;
      end
      @(posedge clock); #1;
      t++;
      start = (t == restart_at);
      char_code = (t == restart_at) ? ~code : 8'($urandom);
      x_origin = 8'($urandom); y_origin = 7'($urandom);
      fg_colour = 3'($urandom); bg_colour = 3'($urandom);
      plot_ready = rdy(mode, t);
      if (t == 4) rom[code] = ~g;
    end
    start = 1'b0;
    rom[code] = g;
    nplots = obs_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL plot_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        failures++;
        $display("FAIL pixel[%0d] got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i,
                 obs_q[i].x, obs_q[i].y, obs_q[i].c,
                 exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
    checks++;
    if (done_cyc != exp_done) begin
      failures++;
      $display("FAIL done_cycle got=%0d want=%0d", done_cyc, exp_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    checks++;
    if ({digit, vga_x, vga_y, vga_colour, plot, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset got=%h,%0d,%0d,%0d,%b%b%b want=all_zero",
               digit, vga_x, vga_y, vga_colour, plot, busy, done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_draw;
    int dc, np;
    rom[8'h41] = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock); #1;
    start = 1'b1; char_code = 8'h41;
    x_origin = 8'd40; y_origin = 7'd50;
    fg_colour = 3'd5; bg_colour = 3'd2; plot_ready = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (vga_x !== 8'd42 || vga_y !== 7'd51 || plot !== 1'b1) begin
      failures++;
      $display("FAIL k10_pixel got=(%0d,%0d,%b) want=(42,51,1)", vga_x, vga_y, plot);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vga_x !== 8'd0) begin
      failures++;
      $display("FAIL reset_abort got plot=%b busy=%b done=%b x=%0d want=0,0,0,0",
               plot, busy, done, vga_x);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run_draw(8'h41, 40, 50, 3'd5, 3'd2, 0, -1, dc, np);
    checks++;
    if (np != 64) begin
      failures++;
      $display("FAIL after_reset_plots got=%0d want=64", np);
    end
  endtask

  task automatic test_stub_ready_high;
    int dc, np;
    rom[8'h30] = 64'h8000_0000_0000_0001;
    run_draw(8'h30, 20, 30, 3'b111, 3'b000, 0, -1, dc, np);
    checks++;
    if (dc != 66 || np != (TRANSP ? 2 : 64)) begin
      failures++;
      $display("FAIL stub_latency got=%0d/%0d want=66/%0d", dc, np, TRANSP ? 2 : 64);
    end
  endtask

  task automatic test_stub_toggle;
    int dc, np;
    rom[8'h30] = 64'h8000_0000_0000_0001;
    run_draw(8'h30, 20, 30, 3'b111, 3'b000, 1, -1, dc, np);
    checks++;
    if (!TRANSP && dc != 130) begin
      failures++;
      $display("FAIL toggle_latency got=%0d want=130", dc);
    end
  endtask

  task automatic test_clip;
    int dc, np;
    rom[8'h7F] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_draw(8'h7F, 156, 116, 3'd6, 3'd1, 0, -1, dc, np);
    checks++;
    if (np != 16 || dc != 66) begin
      failures++;
      $display("FAIL clip got plots=%0d done=%0d want plots=16 done=66", np, dc);
    end
  endtask

  task automatic test_back_to_back;
    int dc, np;
    rom[8'h52] = 64'($urandom) << 32 | 64'($urandom);
    rom[8'hAD] = 64'($urandom) << 32 | 64'($urandom);
    run_draw(8'h52, 10, 10, 3'd4, 3'd3, 0, 5, dc, np);
    start = 1'b1; char_code = 8'hAD;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || digit !== 8'h52) begin
      failures++;
      $display("FAIL start_on_done got busy=%b digit=%h want busy=0 digit=52", busy, digit);
    end
    run_draw(8'h52, 60, 0, 3'd1, 3'd7, 0, -1, dc, np);
    run_draw(8'hAD, 100, 70, 3'd2, 3'd5, 0, -1, dc, np);
  endtask

  task automatic test_transparent;
`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
    int dc, np;
    rom[8'h30] = 64'h8000_0000_0000_0001;
    run_draw(8'h30, 20, 30, 3'b111, 3'b000, 3, -1, dc, np);
    checks++;
    if (np != 2 || dc != 66) begin
      failures++;
      $display("FAIL transparent got plots=%0d done=%0d want 2/66", np, dc);
    end
`endif
  endtask

  task automatic test_random;
    int dc, np;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] code;
      code = 8'($urandom);
      rom[code] = 64'($urandom) << 32 | 64'($urandom);
      for (int i = 0; i < 4096; i++) rpat[i] = 1'($urandom);
      run_draw(code, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               3'($urandom), 3'($urandom), (n % 2 == 0) ? 2 : n % 3,
               int'($urandom_range(1, 40)), dc, np);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 64'($urandom) << 32 | 64'($urandom);
    for (int i = 0; i < 4096; i++) rpat[i] = 1'b1;
    start = 1'b0; char_code = '0; x_origin = '0; y_origin = '0;
    fg_colour = '0; bg_colour = '0; plot_ready = 1'b0;
    test_reset;
    test_stub_ready_high;
    test_stub_toggle;
    test_clip;
    test_back_to_back;
    test_transparent;
    test_reset_mid_draw;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_plotter.md
Name: char_plotter

Overview:
- Consumer side of the character-bitmap lookup. Accepts a character-draw request and drives the 8-bit character code to char_bitmap.
- Latches the returned 64-bit pixelLine, then emits one framebuffer pixel write per cycle (x, y, colour, plot) to the VGA adapter.
- Sits between the CPU's memory-mapped text port and the VGA adapter's write port.

Parameters:
- SCREEN_W, 160, visible width in pixels; writes with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, visible height in pixels; writes with y >= SCREEN_H are suppressed.
- X_W, 8, width of x coordinates.
- Y_W, 7, width of y coordinates.
- COLOR_W, 3, width of colour values.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- char_code  in  8  character to draw.
- x_origin  in  X_W  left column of the glyph cell.
- y_origin  in  Y_W  top row of the glyph cell.
- fg_colour  in  COLOR_W  colour for set bits.
- bg_colour  in  COLOR_W  colour for clear bits.
- digit  out  8  character code presented to char_bitmap.
- pixelLine  in  64  glyph bitmap returned by char_bitmap (combinational).
- plot_ready  in  1  VGA write port can accept a pixel this cycle.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COLOR_W  pixel colour.
- plot  out  1  pixel write valid.
- busy  out  1  high from start acceptance until the done pulse inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate): state=IDLE; digit=0, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0; pixel index=0. Reset mid-draw aborts the glyph with no further writes.
- Bitmap ordering: pixel (row r, col c), with r=0 the top row and c=0 the leftmost column, is pixelLine[63-(8r+c)]. Top row is bits [63:56], MSB on the left.
- Pixel index k runs 0..63 with r=k[5:3] and c=k[2:0], i.e. row-major from the top-left.
- IDLE:
  - busy=0.
  - start=1 → latch char_code into digit, and latch x_origin, y_origin, fg_colour, bg_colour; go to LOAD; busy=1 from the next cycle.
  - start=0 → stay.
- LOAD (1 cycle): pixelLine is now valid for the latched digit; register it into the glyph shadow; k=0; go to DRAW.
- DRAW:
  - Drive vga_x = x0+c and vga_y = y0+r, computed one bit wider than X_W/Y_W so no wrap occurs.
  - vga_colour = fg_colour if the glyph bit is 1, else bg_colour.
  - plot=1 unless the pixel is clipped (x >= SCREEN_W or y >= SCREEN_H), in which case plot=0.
  - Advance k when plot_ready=1, or when the pixel is clipped (a clipped pixel never waits on ready).
  - Outputs are held stable while plot=1 and plot_ready=0.
  - k=63 advancing → go to DONE.
- DONE (1 cycle): done=1, plot=0, busy=1; next state IDLE.
- Minimum latency with plot_ready tied high: start in cycle 0; LOAD in cycle 1; pixels in cycles 2..65; done in cycle 66. Total 67 cycles start-to-done.
- start asserted while busy is ignored; no queueing.
- Glyph contents and colours are snapshotted in LOAD. Changes on char_code, pixelLine or the colour inputs during DRAW have no effect.
- start in the same cycle as done is ignored, because the block is not yet in IDLE. Accepted one cycle later.

Optional Feature:
- CHAR_PLOTTER_TRANSPARENT_BG_EN
- Defined: clear glyph bits produce plot=0 and advance k without waiting on plot_ready; bg_colour is unused. Background pixels in the framebuffer are preserved.
- Undefined: clear bits are written in bg_colour, per Behaviour above.

Test Plan:
- Reset during DRAW at k=10 → next edge: plot=0, busy=0, state IDLE; a subsequent start draws the full 64 pixels.
- pixelLine stub 64'h8000_0000_0000_0001, origin (20,30), fg=3'b111, bg=3'b000, plot_ready=1 → exactly 64 plots:
  - (20,30) colour 7;
  - (27,37) colour 7;
  - all other 62 colour 0;
  - done high in cycle 66 after start.
- Same stimulus with plot_ready toggling 1,0,1,0… → same 64 (x,y,colour) sequence; outputs held during ready-low cycles; done in cycle 130.
- Origin (156,116) with pixelLine all ones → only 16 plots, the pixels with x 156..159 and y 116..119; 48 clipped; total 67 cycles.
- start pulsed again at cycle 5 with a different char_code → ignored; digit unchanged until done; a start in the cycle after done is accepted.
- With CHAR_PLOTTER_TRANSPARENT_BG_EN and the stub 64'h8000_0000_0000_0001 → exactly 2 plots, (20,30) and (27,37); done in cycle 66 even with plot_ready stuck low except during those two pixels.
